// File: rtl/pixel_array_pkg.sv
// Shared definitions for the pixel array readout block.
// Holds the frame FSM state encoding and small sizing helpers used by
// both the top level and the per-pixel channel.
package pixel_array_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READOUT = 3'd4
    } state_e;

    // Full-scale pixel level (all ones) for a given code width; this is
    // both the erase level and the final ramp value.
    function automatic int unsigned erase_level(input int unsigned data_w);
        if (data_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << data_w) - 32'd1;
    endfunction

    // Width of a channel index; never narrower than one bit so that a
    // single-channel build still has a legal index port.
    function automatic int unsigned ch_w(input int unsigned n_ch);
        return (n_ch > 1) ? unsigned'($clog2(n_ch)) : 32'd1;
    endfunction

endpackage

// File: rtl/pixel_channel.sv
// One pixel channel: integrating pixel node, saturating discharge during
// exposure, and a single-slope comparator that latches the shared ramp
// value the first time it reaches the pixel level.
// Optional feature macro: PIXEL_ARRAY_OVF_EN (keeps a per-pixel flag that
// records the pixel discharging all the way to zero).
module pixel_channel
    import pixel_array_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              expose,
    input  logic              convert,
    input  logic [DATA_W-1:0] light,
    input  logic [DATA_W-1:0] ramp,
    // Next-state code so the readout register can capture the value
    // latched on the very last conversion cycle without an extra stage.
    output logic [DATA_W-1:0] code_next
`ifdef PIXEL_ARRAY_OVF_EN
    ,
    output logic              ovf_next
`endif
);

    localparam logic [DATA_W-1:0] ERASE_LVL = DATA_W'(erase_level(DATA_W));

    logic [DATA_W-1:0] pix_q, pix_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic              tripped_q, tripped_d;
`ifdef PIXEL_ARRAY_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Pixel node update, comparator trip detection and code capture.
    always_comb begin
        pix_d     = pix_q;
        code_d    = code_q;
        tripped_d = tripped_q;
`ifdef PIXEL_ARRAY_OVF_EN
        ovf_d     = ovf_q;
`endif
        if (erase) begin
            pix_d     = ERASE_LVL;
            code_d    = '0;
            tripped_d = 1'b0;
`ifdef PIXEL_ARRAY_OVF_EN
            ovf_d     = 1'b0;
`endif
        end else if (expose) begin
            // Discharge clamps at zero instead of wrapping around.
            pix_d = (pix_q > light) ? (pix_q - light) : '0;
`ifdef PIXEL_ARRAY_OVF_EN
            if (pix_d == '0) begin
                ovf_d = 1'b1;
            end
`endif
        end else if (convert && !tripped_q && (ramp >= pix_q)) begin
            // Latch once; later ramp steps leave the code untouched.
            code_d    = ramp;
            tripped_d = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q     <= '0;
            code_q    <= '0;
            tripped_q <= 1'b0;
`ifdef PIXEL_ARRAY_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            pix_q     <= pix_d;
            code_q    <= code_d;
            tripped_q <= tripped_d;
`ifdef PIXEL_ARRAY_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign code_next = code_d;
`ifdef PIXEL_ARRAY_OVF_EN
    assign ovf_next  = ovf_d;
`endif

endmodule

// File: rtl/pixel_array_readout.sv
// Frame sequencer for an N_CH pixel array: erase, exposure, shared
// single-slope ramp conversion, then a valid/ready serial readout of one
// word per channel in channel order.
// Optional feature macro: PIXEL_ARRAY_OVF_EN (adds the rd_ovf port that
// flags channels which saturated to zero during exposure).
module pixel_array_readout
    import pixel_array_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int EXP_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [EXP_W-1:0]         exp_cycles,
    input  logic [N_CH*DATA_W-1:0]   light,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ch_w(N_CH)-1:0]    rd_ch,
`ifdef PIXEL_ARRAY_OVF_EN
    output logic                     rd_ovf,
`endif
    output logic                     rd_last
);

    localparam int                CH_W     = ch_w(N_CH);
    localparam logic [DATA_W-1:0] RAMP_MAX = DATA_W'(erase_level(DATA_W));
    localparam logic [CH_W-1:0]   LAST_IDX = CH_W'(N_CH - 1);

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   exp_len_q, exp_len_d;
    logic [EXP_W-1:0]   exp_cnt_q, exp_cnt_d;
    logic [DATA_W-1:0]  ramp_q, ramp_d;
    logic [CH_W-1:0]    idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [CH_W-1:0]    rd_ch_q, rd_ch_d;
    logic               rd_last_q, rd_last_d;
`ifdef PIXEL_ARRAY_OVF_EN
    logic               rd_ovf_q, rd_ovf_d;
    logic               ovf_next [N_CH];
`endif

    logic [DATA_W-1:0]  code_next [N_CH];
    logic               ch_erase, ch_expose, ch_convert;

    assign ch_erase   = (state_q == ERASE);
    assign ch_expose  = (state_q == EXPOSE);
    assign ch_convert = (state_q == CONVERT);

    // One channel per pixel; all share the phase strobes and the ramp.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pixel_channel #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .erase     (ch_erase),
            .expose    (ch_expose),
            .convert   (ch_convert),
            .light     (light[gi*DATA_W +: DATA_W]),
            .ramp      (ramp_q),
            .code_next (code_next[gi])
`ifdef PIXEL_ARRAY_OVF_EN
            ,
            .ovf_next  (ovf_next[gi])
`endif
        );
    end

    // Frame sequencing plus next values of the registered readout outputs.
    always_comb begin
        state_d   = state_q;
        exp_len_d = exp_len_q;
        exp_cnt_d = exp_cnt_q;
        ramp_d    = ramp_q;
        idx_d     = idx_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_len_d = exp_cycles;
                    state_d   = ERASE;
                end
            end
            ERASE: begin
                exp_cnt_d = '0;
                ramp_d    = '0;
                state_d   = (exp_len_q == '0) ? CONVERT : EXPOSE;
            end
            EXPOSE: begin
                exp_cnt_d = exp_cnt_q + EXP_W'(1);
                if (exp_cnt_d == exp_len_q) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // Full ramp sweep; the last step hands over to readout.
                ramp_d = ramp_q + DATA_W'(1);
                if (ramp_q == RAMP_MAX) begin
                    state_d = READOUT;
                    idx_d   = '0;
                end
            end
            READOUT: begin
                if (rd_valid_q && rd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the next state so they are valid in the same
        // cycle the state is entered and hold while the index is held.
        busy_d     = (state_d != IDLE);
        rd_valid_d = (state_d == READOUT);
        rd_ch_d    = rd_valid_d ? idx_d : '0;
        rd_data_d  = rd_valid_d ? code_next[idx_d] : '0;
        rd_last_d  = rd_valid_d && (idx_d == LAST_IDX);
`ifdef PIXEL_ARRAY_OVF_EN
        rd_ovf_d   = rd_valid_d && ovf_next[idx_d];
`endif
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            exp_len_q  <= '0;
            exp_cnt_q  <= '0;
            ramp_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rd_last_q  <= 1'b0;
`ifdef PIXEL_ARRAY_OVF_EN
            rd_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            exp_len_q  <= exp_len_d;
            exp_cnt_q  <= exp_cnt_d;
            ramp_q     <= ramp_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            rd_last_q  <= rd_last_d;
`ifdef PIXEL_ARRAY_OVF_EN
            rd_ovf_q   <= rd_ovf_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;
    assign rd_last  = rd_last_q;
`ifdef PIXEL_ARRAY_OVF_EN
    assign rd_ovf   = rd_ovf_q;
`endif

endmodule

// File: tb/tb_pixel_array_readout.sv
// Bench for pixel_array_readout: runs whole frames with constant light per
// frame and compares each read word with codes computed from the frame
// arithmetic (full scale minus total discharge, clamped at zero).
module tb_pixel_array_readout;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int EXP_W  = 16;
    localparam int FULL   = (1 << DATA_W) - 1;
    localparam int CONV   = 1 << DATA_W;
    localparam int BUDGET = 2000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [EXP_W-1:0]       exp_cycles;
    logic [N_CH*DATA_W-1:0] light;
    logic                   busy, done, rd_valid, rd_ready, rd_last, rd_ovf;
    logic [DATA_W-1:0]      rd_data;
    logic [1:0]             rd_ch;

    int tests_run    = 0;
    int tests_failed = 0;

    // Results of the most recent frame.
    int   n_xfer, first_valid_k, done_k, done_cnt, hold_viol, last_xfer_k;
    logic done_busy, timeout;
    int   w_data [16];
    int   w_ch   [16];
    int   w_last [16];
    int   w_ovf  [16];

    always #5 clk = ~clk;

    pixel_array_readout #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .exp_cycles (exp_cycles),
        .light      (light),
        .busy       (busy),
        .done       (done),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_ch      (rd_ch),
`ifdef PIXEL_ARRAY_OVF_EN
        .rd_ovf     (rd_ovf),
`endif
        .rd_last    (rd_last)
    );
`ifndef PIXEL_ARRAY_OVF_EN
    assign rd_ovf = 1'b0;
`endif

    // Reference: pixel starts at full scale, loses lv per exposure cycle.
    function automatic int ref_code(input int e, input int lv);
        int v;
        v = FULL - e * lv;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int ref_ovf(input int e, input int lv);
        return (e * lv >= FULL) ? 1 : 0;
    endfunction

    function automatic int light_of(input logic [N_CH*DATA_W-1:0] l, input int c);
        return int'(l[c*DATA_W +: DATA_W]);
    endfunction

    function automatic logic [N_CH*DATA_W-1:0] rand_light(input int hi);
        logic [N_CH*DATA_W-1:0] l;
        for (int c = 0; c < N_CH; c++) l[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, hi));
        return l;
    endfunction

    // Runs one frame from the current negedge; mode 0 ready high, 1 stalls
    // five cycles on channel 1, 2 random ready. spur_k pulses start again.
    task automatic do_frame(input int e, input logic [N_CH*DATA_W-1:0] l,
                            input int mode, input int spur_k, input int tail);
        int k, stall;
        logic held_v, hl, ho;
        logic [DATA_W-1:0] hd;
        logic [1:0] hc;
        n_xfer = 0; first_valid_k = -1; done_k = -1; done_cnt = 0;
        done_busy = 1'b1; hold_viol = 0; last_xfer_k = -1; timeout = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_data[i] = -1; w_ch[i] = -1; w_last[i] = -1; w_ovf[i] = -1;
        end
        stall = 0; held_v = 1'b0; k = 0; hd = '0; hc = '0; hl = 1'b0; ho = 1'b0;
        start = 1'b1; exp_cycles = EXP_W'(e); light = l; rd_ready = 1'b1;
        while (k < BUDGET) begin
            @(negedge clk);
            k++;
            start = (k == spur_k);
            if (held_v) begin
                if (rd_valid !== 1'b1 || rd_data !== hd || rd_ch !== hc ||
                    rd_last !== hl || rd_ovf !== ho) hold_viol++;
                held_v = 1'b0;
            end
            if (rd_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    done_busy = busy;
                end
            end
            if (done_k >= 0 && k >= done_k + tail) break;
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) begin
                if (mode == 1 && rd_ch == 2'd1 && stall < 5) begin
                    rd_ready = 1'b0;
                    stall++;
                end else if (mode == 2) begin
                    rd_ready = 1'($urandom_range(0, 1));
                end
                if (rd_ready) begin
                    if (n_xfer < 16) begin
                        w_data[n_xfer] = int'(rd_data);
                        w_ch[n_xfer]   = int'(rd_ch);
                        w_last[n_xfer] = int'(rd_last);
                        w_ovf[n_xfer]  = int'(rd_ovf);
                    end
                    n_xfer++;
                    last_xfer_k = k;
                end else begin
                    held_v = 1'b1; hd = rd_data; hc = rd_ch; hl = rd_last; ho = rd_ovf;
                end
            end
        end
        start = 1'b0;
        timeout = (done_k < 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rd_ready = 1'b1; exp_cycles = '0; light = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        tests_run++; if (rd_data !== '0) begin tests_failed++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        tests_run++; if (rd_ch !== '0) begin tests_failed++; $display("FAIL reset_rd_ch: got %0d expected 0", rd_ch); end
        tests_run++; if (rd_last !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_last: got %b expected 0", rd_last); end
        tests_run++; if (rd_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_ovf: got %b expected 0", rd_ovf); end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_basic();
        logic [N_CH*DATA_W-1:0] l;
        l = {8'd30, 8'd10, 8'd1, 8'd0};
        do_frame(10, l, 0, -1, 3);
        tests_run++; if (timeout) begin tests_failed++; $display("FAIL basic_timeout: got no done expected done"); end
        tests_run++; if (first_valid_k != 2 + 10 + CONV) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", first_valid_k, 2 + 10 + CONV); end
        tests_run++; if (n_xfer != N_CH) begin tests_failed++; $display("FAIL basic_xfers: got %0d expected %0d", n_xfer, N_CH); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_ch[c] != c) begin tests_failed++; $display("FAIL basic_ch%0d: got %0d expected %0d", c, w_ch[c], c); end
            tests_run++; if (w_data[c] != ref_code(10, light_of(l, c))) begin tests_failed++; $display("FAIL basic_code ch%0d: got %0d expected %0d", c, w_data[c], ref_code(10, light_of(l, c))); end
            tests_run++; if (w_last[c] != ((c == N_CH - 1) ? 1 : 0)) begin tests_failed++; $display("FAIL basic_last ch%0d: got %0d", c, w_last[c]); end
`ifdef PIXEL_ARRAY_OVF_EN
            tests_run++; if (w_ovf[c] != ref_ovf(10, light_of(l, c))) begin tests_failed++; $display("FAIL basic_ovf ch%0d: got %0d expected %0d", c, w_ovf[c], ref_ovf(10, light_of(l, c))); end
`endif
        end
        tests_run++; if (last_xfer_k - first_valid_k != N_CH - 1) begin tests_failed++; $display("FAIL basic_stream: got %0d cycles expected %0d", last_xfer_k - first_valid_k + 1, N_CH); end
        tests_run++; if (done_k != last_xfer_k + 1) begin tests_failed++; $display("FAIL basic_done_time: got %0d expected %0d", done_k, last_xfer_k + 1); end
        tests_run++; if (done_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_done_busy: got %b expected 0", done_busy); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_pulse: got %0d expected 1", done_cnt); end
        $display("[TB] basic: exp=10 codes %0d %0d %0d %0d", w_data[0], w_data[1], w_data[2], w_data[3]);
    endtask

    task automatic test_zero_exposure();
        logic [N_CH*DATA_W-1:0] l;
        l = rand_light(255);
        do_frame(0, l, 0, -1, 1);
        tests_run++; if (first_valid_k != 2 + CONV) begin tests_failed++; $display("FAIL zero_latency: got %0d expected %0d", first_valid_k, 2 + CONV); end
        tests_run++; if (n_xfer != N_CH) begin tests_failed++; $display("FAIL zero_xfers: got %0d expected %0d", n_xfer, N_CH); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_data[c] != FULL) begin tests_failed++; $display("FAIL zero_code ch%0d: got %0d expected %0d", c, w_data[c], FULL); end
        end
        $display("[TB] zero_exposure: latency %0d", first_valid_k);
    endtask

    task automatic test_backpressure();
        logic [N_CH*DATA_W-1:0] l;
        int e;
        e = $urandom_range(1, 20);
        l = rand_light(40);
        do_frame(e, l, 1, -1, 1);
        tests_run++; if (hold_viol != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_viol); end
        tests_run++; if (n_xfer != N_CH) begin tests_failed++; $display("FAIL bp_xfers: got %0d expected %0d", n_xfer, N_CH); end
        tests_run++; if (last_xfer_k - first_valid_k != N_CH - 1 + 5) begin tests_failed++; $display("FAIL bp_span: got %0d expected %0d", last_xfer_k - first_valid_k, N_CH - 1 + 5); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_ch[c] != c || w_data[c] != ref_code(e, light_of(l, c))) begin
                tests_failed++; $display("FAIL bp_word %0d: got ch%0d=%0d expected ch%0d=%0d", c, w_ch[c], w_data[c], c, ref_code(e, light_of(l, c)));
            end
        end
        $display("[TB] backpressure: exp=%0d transfers %0d", e, n_xfer);
    endtask

    task automatic test_start_ignored();
        logic [N_CH*DATA_W-1:0] l;
        int e;
        e = $urandom_range(1, 20);
        l = rand_light(40);
        do_frame(e, l, 0, e + 2 + 100, 6);
        tests_run++; if (first_valid_k != 2 + e + CONV) begin tests_failed++; $display("FAIL spur_latency: got %0d expected %0d", first_valid_k, 2 + e + CONV); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL spur_done_count: got %0d expected 1", done_cnt); end
        tests_run++; if (n_xfer != N_CH) begin tests_failed++; $display("FAIL spur_xfers: got %0d expected %0d", n_xfer, N_CH); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL spur_idle: got busy %b expected 0", busy); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_data[c] != ref_code(e, light_of(l, c))) begin tests_failed++; $display("FAIL spur_code ch%0d: got %0d expected %0d", c, w_data[c], ref_code(e, light_of(l, c))); end
        end
        $display("[TB] start_ignored: exp=%0d done pulses %0d", e, done_cnt);
    endtask

    task automatic test_reset_midconvert();
        logic [N_CH*DATA_W-1:0] l;
        int e;
        e = $urandom_range(1, 20);
        start = 1'b1; exp_cycles = EXP_W'(e); light = rand_light(40); rd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (e + 61) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", rd_valid); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_stays_idle: got %b expected 0", busy); end
        e = $urandom_range(0, 30);
        l = rand_light(40);
        do_frame(e, l, 0, -1, 1);
        tests_run++; if (first_valid_k != 2 + e + CONV) begin tests_failed++; $display("FAIL rst_latency: got %0d expected %0d", first_valid_k, 2 + e + CONV); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_data[c] != ref_code(e, light_of(l, c))) begin tests_failed++; $display("FAIL rst_code ch%0d: got %0d expected %0d", c, w_data[c], ref_code(e, light_of(l, c))); end
        end
        $display("[TB] reset_midconvert: new frame exp=%0d transfers %0d", e, n_xfer);
    endtask

    task automatic test_saturation();
        logic [N_CH*DATA_W-1:0] l;
        l = {N_CH{8'd255}};
        do_frame(3, l, 0, -1, 1);
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_data[c] != 0) begin tests_failed++; $display("FAIL sat_code ch%0d: got %0d expected 0", c, w_data[c]); end
`ifdef PIXEL_ARRAY_OVF_EN
            tests_run++; if (w_ovf[c] != 1) begin tests_failed++; $display("FAIL sat_ovf ch%0d: got %0d expected 1", c, w_ovf[c]); end
`endif
        end
        $display("[TB] saturation: codes %0d %0d %0d %0d", w_data[0], w_data[1], w_data[2], w_data[3]);
    endtask

    task automatic test_random_frames();
        logic [N_CH*DATA_W-1:0] l;
        int e;
        for (int f = 0; f < 4; f++) begin
            e = $urandom_range(0, 40);
            l = rand_light(($urandom_range(0, 1) == 0) ? 12 : 255);
            do_frame(e, l, 2, -1, 1);
            tests_run++; if (timeout || n_xfer != N_CH || hold_viol != 0) begin
                tests_failed++; $display("FAIL rand_frame%0d: got xfers=%0d holdviol=%0d expected xfers=%0d holdviol=0", f, n_xfer, hold_viol, N_CH);
            end
            for (int c = 0; c < N_CH; c++) begin
                tests_run++; if (w_ch[c] != c || w_data[c] != ref_code(e, light_of(l, c))) begin
                    tests_failed++; $display("FAIL rand_word f%0d w%0d: got ch%0d=%0d expected ch%0d=%0d", f, c, w_ch[c], w_data[c], c, ref_code(e, light_of(l, c)));
                end
`ifdef PIXEL_ARRAY_OVF_EN
                tests_run++; if (w_ovf[c] != ref_ovf(e, light_of(l, c))) begin tests_failed++; $display("FAIL rand_ovf f%0d ch%0d: got %0d expected %0d", f, c, w_ovf[c], ref_ovf(e, light_of(l, c))); end
`endif
            end
            $display("[TB] random frame %0d: exp=%0d transfers %0d", f, e, n_xfer);
        end
    endtask

    task automatic test_back_to_back();
        logic [N_CH*DATA_W-1:0] l;
        int e;
        e = $urandom_range(1, 15);
        do_frame(e, rand_light(40), 0, -1, 0);
        tests_run++; if (timeout) begin tests_failed++; $display("FAIL b2b_first_timeout: got no done expected done"); end
        e = $urandom_range(1, 15);
        l = rand_light(40);
        do_frame(e, l, 0, -1, 1);
        tests_run++; if (first_valid_k != 2 + e + CONV) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected %0d", first_valid_k, 2 + e + CONV); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++; if (w_data[c] != ref_code(e, light_of(l, c))) begin tests_failed++; $display("FAIL b2b_code ch%0d: got %0d expected %0d", c, w_data[c], ref_code(e, light_of(l, c))); end
        end
        $display("[TB] back_to_back: second frame exp=%0d latency %0d", e, first_valid_k);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_exposure();
        test_backpressure();
        test_start_ignored();
        test_reset_midconvert();
        test_saturation();
        test_random_frames();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the bench itself stops advancing.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
